// File: rtl/vsync_frame_gate_if.sv
// Signal bundle between the CCD mode switches / VGA timing and the per-stage enables.
// The master drives vsync, requests and the frame limit; the slave (the gate) returns the enables.
interface vsync_frame_gate_if #(
    parameter int NUM_CH = 4,
    parameter int FCNT_W = 8
);
    logic              i_vsync;
    logic [NUM_CH-1:0] i_req;
    logic [FCNT_W-1:0] i_frame_limit;
    logic [NUM_CH-1:0] o_active;
    logic [NUM_CH-1:0] o_done;
    logic              o_frame_start;
    logic [FCNT_W-1:0] o_frame_cnt;

    modport master (
        output i_vsync, i_req, i_frame_limit,
        input  o_active, o_done, o_frame_start, o_frame_cnt
    );

    modport slave (
        input  i_vsync, i_req, i_frame_limit,
        output o_active, o_done, o_frame_start, o_frame_cnt
    );
endinterface

// File: rtl/vsync_frame_gate.sv
// Frame-aligned per-channel enable controller: request levels become active windows
// that open and close only on vsync rising edges, with optional per-run frame limits.
module vsync_frame_gate #(
    parameter int NUM_CH = 4,
    parameter int FCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    vsync_frame_gate_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_q    [NUM_CH];
    logic [FCNT_W-1:0] run_cnt_q  [NUM_CH];
    logic [FCNT_W-1:0] lim_q      [NUM_CH];

    logic              vs_d;
    logic              rise;
    logic [NUM_CH-1:0] active_p1;
    logic [NUM_CH-1:0] done_p1;
    logic              frame_start_p1;
    logic [FCNT_W-1:0] frame_cnt_p1;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // vs_d resets high so a vsync already asserted at reset release is not an edge
    assign rise = bus.i_vsync & ~vs_d;

    // Stage p1: edge-qualified FSM updates; every output is registered here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_d           <= 1'b1;
            frame_start_p1 <= 1'b0;
            frame_cnt_p1   <= '0;
            active_p1      <= '0;
            done_p1        <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]   <= IDLE;
                run_cnt_q[ch] <= '0;
                lim_q[ch]     <= '0;
            end
        end else begin
            vs_d           <= bus.i_vsync;
            frame_start_p1 <= rise;
            if (rise) frame_cnt_p1 <= frame_cnt_p1 + 1'b1;

            for (int ch = 0; ch < NUM_CH; ch++) begin
                done_p1[ch] <= 1'b0;
                case (state_q[ch])
                    IDLE, ARM: begin
                        active_p1[ch] <= 1'b0;
                        if (!bus.i_req[ch]) begin
                            state_q[ch] <= IDLE;
                        end else if (rise) begin
                            state_q[ch]   <= RUN;
                            active_p1[ch] <= 1'b1;
                            run_cnt_q[ch] <= FCNT_W'(1);
                            lim_q[ch]     <= bus.i_frame_limit;
                        end else begin
                            state_q[ch] <= ARM;
                        end
                    end
                    RUN: begin
                        active_p1[ch] <= 1'b1;
                        if (rise && !bus.i_req[ch]) begin
                            state_q[ch]   <= IDLE;
                            active_p1[ch] <= 1'b0;
                            done_p1[ch]   <= 1'b1;
                        end else if (rise && lim_q[ch] != '0 && run_cnt_q[ch] == lim_q[ch]) begin
                            // Checked on the rise that would begin frame lim+1
                            state_q[ch]   <= HOLD;
                            active_p1[ch] <= 1'b0;
                            done_p1[ch]   <= 1'b1;
                        end else if (rise) begin
                            run_cnt_q[ch] <= sat_inc(run_cnt_q[ch]);
                        end else if (!bus.i_req[ch]) begin
                            state_q[ch] <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        active_p1[ch] <= 1'b1;
                        if (rise) begin
                            state_q[ch]   <= IDLE;
                            active_p1[ch] <= 1'b0;
                            done_p1[ch]   <= 1'b1;
                        end else if (bus.i_req[ch]) begin
                            state_q[ch] <= RUN;
                        end
                    end
                    HOLD: begin
                        active_p1[ch] <= 1'b0;
                        if (!bus.i_req[ch]) state_q[ch] <= IDLE;
                    end
                    default: begin
                        state_q[ch]   <= IDLE;
                        active_p1[ch] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_active      = active_p1;
    assign bus.o_done        = done_p1;
    assign bus.o_frame_start = frame_start_p1;
    assign bus.o_frame_cnt   = frame_cnt_p1;

endmodule

// File: doc/vsync_frame_gate.md
# vsync_frame_gate

Multi-channel, frame-aligned enable controller for the camera/VGA datapath. Each channel's processing-request level is converted into an `o_active` window that opens and closes only on VGA vertical-sync rising edges, so downstream stages (grayscale, blob, overlay) always see whole frames. Each channel has an optional per-run frame limit and a completion pulse. A shared frame counter is also provided. The block sits between the CCD processing-mode switches and the per-stage start inputs.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent channels.
- `FCNT_W`, 8, width of frame counters and the frame limit.

Ports:
- `i_clk`, in, 1, system clock. Single clock domain; all inputs are synchronous to it.
- `i_rst`, in, 1, reset. Synchronous and active-high.
- `i_vsync`, in, 1, VGA vertical sync level, active high.
- `i_req`, in, `NUM_CH`, per-channel processing request, level.
- `i_frame_limit`, in, `FCNT_W`, frames per run. 0 means unlimited.
- `o_active`, out, `NUM_CH`, per-channel frame-aligned enable.
- `o_done`, out, `NUM_CH`, one-cycle pulse when a channel's run ends.
- `o_frame_start`, out, 1, one-cycle pulse on each vsync rising edge.
- `o_frame_cnt`, out, `FCNT_W`, count of vsync rising edges since reset. Wraps at 2^`FCNT_W`.

## Operation
- Edge detection:
  - `vs_d` is `i_vsync` delayed by one register.
  - `rise = i_vsync & ~vs_d`.
  - `vs_d` resets to 1, so a vsync that is already high when reset releases is not an edge.
- `o_frame_start` is the registered `rise`. `o_frame_cnt` increments on `rise` and wraps modulo 2^`FCNT_W`.
- Each channel has its own FSM, its own `run_cnt` (`FCNT_W` bits) and its own latched limit `lim`. States:
  - IDLE: active=0. If `req` and `rise` → RUN. Else if `req` → ARM.
  - ARM: active=0. If `~req` → IDLE (cancel, no done). Else if `rise` → RUN.
  - RUN: active=1.
    - If `rise` and `~req` → IDLE, active=0, done.
    - Else if `rise` and `lim!=0` and `run_cnt==lim` → HOLD, active=0, done.
    - Else if `rise` → `run_cnt` increments, saturating at all-ones.
    - Else if `~req` → DRAIN.
  - DRAIN: active=1, finishing the current frame. If `rise` → IDLE, active=0, done. Else if `req` → RUN (drain cancelled, `run_cnt` kept).
  - HOLD: active=0. If `~req` → IDLE. A run that hit its limit does not restart until `req` is dropped.
- Entry into RUN, from IDLE or ARM: `run_cnt` set to 1 and `lim` latched from `i_frame_limit`. `i_frame_limit` changes during a run have no effect.
- Limit check precedence: the check happens on the same rise that would start frame `lim+1`. With `lim=N`, active spans exactly N frames.
- State encoding is 3 bits, with default → IDLE. Each channel is independent; there is no arbitration between channels.

## Timing
- Reset values:
  - `o_active`=0, `o_done`=0, `o_frame_start`=0, `o_frame_cnt`=0.
  - All FSMs in IDLE, `run_cnt`=0, `lim`=0, `vs_d`=1.
- Reset asserted mid-run forces the reset values on the next edge. No done pulse is issued.
- All outputs are registered.
- Frame boundaries: if `i_vsync` is first sampled high at edge k, then from edge k:
  - `o_frame_start`=1 for exactly one cycle;
  - `o_active` opens or closes;
  - `o_done` pulses.
- `i_req` latency: `i_req` changes are seen at the next edge. `o_active` never changes except on a rise cycle.
- `i_vsync` held high for many cycles produces one rise only.
- The same rise can close one channel while opening another.

## Test plan
- Single run. `i_req[0]`=1 in mid-frame; vsync rises at cycle 100; `i_req[0]`=0 at cycle 250; next rise at cycle 400. Required: `o_active[0]` is high from edge 100 to edge 400, low from 400; `o_done[0]` is a single pulse at 400.
- Simultaneous events. `i_req[1]` rises in the same cycle as a vsync rise → `o_active[1]` is high from that edge. A later `req` deassert coinciding with a rise → active drops at that edge and done pulses.
- Frame limit. `i_frame_limit`=3, `req` held high for 6 frames → `o_active` high for exactly 3 frames, then HOLD with no re-arm. Drop `req`, raise it again → a new 3-frame run starts on the next rise.
- Cancels. A `req` pulse that drops before any rise (ARM→IDLE) → no active, no done. In DRAIN, `req` reasserted before the rise → active stays high, no done pulse.
- Counter and reset. `i_vsync` already high at reset release → `o_frame_cnt` stays 0. 260 rises with `FCNT_W`=8 → count wraps to 4. `i_rst` asserted mid-RUN → all outputs 0 at the next edge, no done.
